sror_datapath: RTL and testbench

//  Stochastic random-order (SROr) Boolean-network simulator core.
//  - Holds a RULES-bit network state.
//  - Each run cycle, a 64-bit seeded LFSR picks one element, which is updated from its rule.
//  - Supports one knocked-out (inhibited) element, an iteration counter and a steady-state flag.
//  - Driven by a host/sequencer that seeds it, loads the inhibitor, pulses start and polls

---
 rtl/sror_pkg.sv | 39 +++
 rtl/sror_if.sv | 23 ++
 rtl/sror_lfsr64.sv | 23 ++
 rtl/sror_datapath.sv | 108 ++++++++++
 tb/tb_sror_datapath.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sror_pkg.sv
// Shared parameters, types and the network rule for the SROr Boolean-network core.
// To simulate a different network, edit rule_eval only.
package sror_pkg;

   localparam int RULES            = 8;
   localparam int LOG_RULES        = 3;
   localparam int LOG_ITER         = 10;
   localparam int ITERATION_NUMBER = 1000;

   localparam logic [RULES-1:0] INIT_STATE = 8'h01;
   localparam logic [63:0]      LFSR_TAPS  = 64'hD800_0000_0000_0000;

   typedef logic [RULES-1:0]     state_t;
   typedef logic [LOG_RULES-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } phase_t;

   // Ring-OR network: element 0 is constantly driven high, every other element
   // ORs its two ring neighbours; a knocked-out element reads as 0 everywhere.
   function automatic logic rule_eval(input idx_t   idx,
                                      input state_t s,
                                      input logic   inh_valid,
                                      input idx_t   inh_idx);
      state_t eff;
      idx_t   lo;
      idx_t   hi;
      eff = s;
      if (inh_valid) eff[inh_idx] = 1'b0;
      lo = idx - 1'b1;
      hi = (idx == idx_t'(RULES - 1)) ? '0 : idx + 1'b1;
      if (idx == '0) return 1'b1;
      return eff[lo] | eff[hi];
   endfunction

endpackage

// File: rtl/sror_if.sv
// Host-side bus of the SROr core: run control, knockout selection, seed and observed state.
interface sror_if;
   import sror_pkg::*;

   logic                start;
   logic                ld_inhibitor;
   idx_t                sel_inhibitor;
   logic [63:0]         seed;
   state_t              network_state;
   logic                steady_state;
   logic [LOG_ITER-1:0] iteration_number;

   modport master (
      output start, ld_inhibitor, sel_inhibitor, seed,
      input  network_state, steady_state, iteration_number
   );

   modport slave (
      input  start, ld_inhibitor, sel_inhibitor, seed,
      output network_state, steady_state, iteration_number
   );

endinterface

// File: rtl/sror_lfsr64.sv
// 64-bit Galois LFSR (taps 64,63,61,60); next is the value the register takes when enabled.
module sror_lfsr64
   import sror_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic [63:0] load_value,
   input  logic        enable,
   output logic [63:0] next
);

   logic [63:0] state;

   assign next = {1'b0, state[63:1]} ^ (state[0] ? LFSR_TAPS : 64'h0);

   always_ff @(posedge clk) begin
      if (load)
         state <= load_value;
      else if (enable)
         state <= next;
   end

endmodule

// File: rtl/sror_datapath.sv
// SROr core: one randomly chosen element is re-evaluated per run cycle, with an
// optional knocked-out element, a saturating step counter and a fixpoint detector.
module sror_datapath
   import sror_pkg::*;
(
   input  logic clk,
   input  logic rst,
   sror_if.slave bus
);

   phase_t              phase;
   phase_t              phase_next;
   logic                running;
   logic [63:0]         seed_value;
   logic [63:0]         lfsr_next;
   idx_t                step_idx;
   state_t              net;
   state_t              net_next;
   idx_t                inh_idx;
   idx_t                inh_idx_next;
   logic                inh_valid;
   logic                inh_valid_next;
   logic [LOG_ITER-1:0] iter;
   logic                steady;
   logic                fixpoint;
   logic                unused_lfsr_bits;

   assign running          = (phase == RUN);
   assign seed_value       = (bus.seed == 64'h0) ? 64'h1 : bus.seed;
   assign step_idx         = lfsr_next[LOG_RULES-1:0];
   assign unused_lfsr_bits = ^lfsr_next[63:LOG_RULES];

   sror_lfsr64 u_lfsr (
      .clk        (clk),
      .load       (rst),
      .load_value (seed_value),
      .enable     (running),
      .next       (lfsr_next)
   );

   always_comb begin
      inh_idx_next   = inh_idx;
      inh_valid_next = inh_valid;
      if (bus.ld_inhibitor) begin
         inh_idx_next   = bus.sel_inhibitor;
         inh_valid_next = (32'(bus.sel_inhibitor) < RULES);
      end
   end

   // The update uses the inhibitor in force this cycle; a fresh load clears its bit at this edge.
   always_comb begin
      net_next = net;
      if (running && (32'(step_idx) < RULES) && !(inh_valid && (inh_idx == step_idx)))
         net_next[step_idx] = rule_eval(step_idx, net, inh_valid, inh_idx);
      if (inh_valid_next)
         net_next[inh_idx_next] = 1'b0;
   end

   always_comb begin
      fixpoint = 1'b1;
      for (int i = 0; i < RULES; i++) begin
         if (inh_valid && (inh_idx == idx_t'(i)))
            fixpoint = fixpoint & ~net[i];
         else
            fixpoint = fixpoint & (rule_eval(idx_t'(i), net, inh_valid, inh_idx) == net[i]);
      end
   end

   always_comb begin
      phase_next = phase;
      case (phase)
         IDLE, DONE: if (bus.start) phase_next = RUN;
         RUN:        if (iter == LOG_ITER'(ITERATION_NUMBER - 1)) phase_next = DONE;
         default:    phase_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         phase <= IDLE;
      else
         phase <= phase_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         net       <= INIT_STATE;
         iter      <= '0;
         steady    <= 1'b0;
         inh_valid <= 1'b0;
         inh_idx   <= '0;
      end else begin
         net       <= net_next;
         steady    <= fixpoint;
         inh_valid <= inh_valid_next;
         inh_idx   <= inh_idx_next;
         if (running)
            iter <= iter + 1'b1;
         else if (bus.start)
            iter <= '0;
      end
   end

   assign bus.network_state    = net;
   assign bus.steady_state     = steady;
   assign bus.iteration_number = iter;

endmodule

// File: tb/tb_sror_datapath.sv
// Randomised and directed bench for sror_datapath against a bit-level behavioural model.
module tb_sror_datapath;
   import sror_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sror_if bus();

   sror_datapath dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   bit              m_valid = 1'b0;
   state_t          m_state;
   int              m_iter;
   bit              m_steady;
   bit              m_running;
   bit              m_inh_valid;
   int              m_inh_idx;
   longint unsigned m_lfsr;

   state_t trace[$];

   function automatic bit bit_of(state_t s, int k);
      return 1'(s >> k);
   endfunction

   function automatic state_t with_bit(state_t s, int k, bit v);
      state_t m;
      m = state_t'(1) << k;
      return v ? (s | m) : (s & ~m);
   endfunction

   function automatic bit model_rule(int i, state_t s, bit iv, int ii);
      state_t e;
      e = iv ? with_bit(s, ii, 1'b0) : s;
      if (i == 0) return 1'b1;
      return bit_of(e, i - 1) | bit_of(e, (i + 1) % RULES);
   endfunction

   function automatic bit model_fixpoint(state_t s, bit iv, int ii);
      for (int k = 0; k < RULES; k++) begin
         if (iv && k == ii) begin
            if (bit_of(s, k)) return 1'b0;
         end else if (model_rule(k, s, iv, ii) != bit_of(s, k)) begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      state_t ns;
      bit     steady_n;
      int     idx;
      if (rst) begin
         m_state     = INIT_STATE;
         m_iter      = 0;
         m_steady    = 1'b0;
         m_running   = 1'b0;
         m_inh_valid = 1'b0;
         m_inh_idx   = 0;
         m_lfsr      = (bus.seed == 64'h0) ? 64'd1 : bus.seed;
         m_valid     = 1'b1;
         return;
      end
      if (!m_valid) return;
      steady_n = model_fixpoint(m_state, m_inh_valid, m_inh_idx);
      ns = m_state;
      if (m_running) begin
         m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 64'd1) != 0) ? 64'hD800_0000_0000_0000 : 64'd0);
         idx = int'(m_lfsr % (64'd1 << LOG_RULES));
         if (idx < RULES && !(m_inh_valid && idx == m_inh_idx))
            ns = with_bit(ns, idx, model_rule(idx, m_state, m_inh_valid, m_inh_idx));
         m_iter++;
         if (m_iter == ITERATION_NUMBER) m_running = 1'b0;
      end else if (bus.start) begin
         m_running = 1'b1;
         m_iter    = 0;
      end
      if (bus.ld_inhibitor) begin
         m_inh_idx   = int'(bus.sel_inhibitor);
         m_inh_valid = (m_inh_idx < RULES);
      end
      if (m_inh_valid) ns = with_bit(ns, m_inh_idx, 1'b0);
      m_state  = ns;
      m_steady = steady_n;
   endtask

   always @(posedge clk) model_step();

   task automatic check_output(string name, longint unsigned act, longint unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Every cycle after the first reset the DUT must track the model exactly.
   always @(negedge clk) begin
      if (m_valid) begin
         check_output("network_state", 64'(bus.network_state), 64'(m_state));
         check_output("iteration_number", 64'(bus.iteration_number), 64'(m_iter));
         check_output("steady_state", 64'(bus.steady_state), 64'(m_steady));
      end
   end

   task automatic apply_stimulus(bit r, bit s, bit l, int sel);
      @(negedge clk);
      rst               = r;
      bus.start         = s;
      bus.ld_inhibitor  = l;
      bus.sel_inhibitor = idx_t'(sel);
   endtask

   task automatic idle_cycles(int n);
      for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic reset_with_seed(logic [63:0] sd);
      bus.seed = sd;
      apply_stimulus(1'b1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic run_until_model_iter(int target, int budget);
      int k;
      k = 0;
      while (m_iter != target && k < budget) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 0);
         k++;
      end
      if (k >= budget) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL wait_iter_%0d: got %0d, expected %0d", target, m_iter, target);
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus.start         = 1'b0;
      bus.ld_inhibitor  = 1'b0;
      bus.sel_inhibitor = '0;
      bus.seed          = 64'h0;

      // Reset with seed 0: LFSR falls back to 1, and nothing moves without start.
      reset_with_seed(64'h0);
      check_output("rst_state", 64'(bus.network_state), 64'h01);
      check_output("rst_iter", 64'(bus.iteration_number), 64'd0);
      check_output("rst_steady", 64'(bus.steady_state), 64'd0);
      check_output("model_lfsr_seed0", m_lfsr, 64'd1);
      idle_cycles(20);
      check_output("idle_iter", 64'(bus.iteration_number), 64'd0);
      check_output("idle_state", 64'(bus.network_state), 64'h01);
      check_output("idle_steady", 64'(bus.steady_state), 64'd0);

      // Seed 1: first step must land on the tap constant and count once.
      reset_with_seed(64'h1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      idle_cycles(2);
      check_output("model_lfsr_step1", m_lfsr, 64'hD800_0000_0000_0000);
      check_output("first_step_iter", 64'(bus.iteration_number), 64'd1);

      // Full run, recording the expected trace for a repeat with the same seed.
      reset_with_seed(64'h0123_4567_89AB_CDEF);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      trace.delete();
      for (int k = 0; k < 1005; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 0);
         trace.push_back(m_state);
      end
      check_output("run_final_iter", 64'(bus.iteration_number), 64'd1000);
      check_output("run_final_state", 64'(bus.network_state), 64'hFF);
      check_output("run_final_steady", 64'(bus.steady_state), 64'd1);

      reset_with_seed(64'h0123_4567_89AB_CDEF);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      for (int k = 0; k < 1005; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 0);
         check_output("replay_state", 64'(bus.network_state), 64'(trace[k]));
      end

      // Knock out element 3 before the run.
      reset_with_seed(64'hCAFE_F00D_1234_5678);
      apply_stimulus(1'b0, 1'b0, 1'b1, 3);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      for (int k = 0; k < 1005; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 0);
         check_output("inh_bit3", 64'(bus.network_state[3]), 64'd0);
      end
      check_output("inh_final_state", 64'(bus.network_state), 64'hF7);
      check_output("inh_final_steady", 64'(bus.steady_state), 64'd1);

      // start during RUN is ignored; reset mid-run clears everything including the inhibitor.
      reset_with_seed(64'h5555_AAAA_0F0F_F0F0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      idle_cycles(101);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0);
      check_output("start_in_run_iter", 64'(bus.iteration_number), 64'd102);
      apply_stimulus(1'b0, 1'b0, 1'b1, 5);
      run_until_model_iter(499, 600);
      apply_stimulus(1'b1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0);
      check_output("midrun_rst_state", 64'(bus.network_state), 64'h01);
      check_output("midrun_rst_iter", 64'(bus.iteration_number), 64'd0);
      check_output("midrun_rst_steady", 64'(bus.steady_state), 64'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      idle_cycles(1005);
      check_output("post_rst_final_state", 64'(bus.network_state), 64'hFF);
      check_output("post_rst_final_iter", 64'(bus.iteration_number), 64'd1000);

      // start in DONE restarts the counter from zero.
      apply_stimulus(1'b0, 1'b1, 1'b0, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0);
      check_output("restart_iter0", 64'(bus.iteration_number), 64'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0);
      check_output("restart_iter1", 64'(bus.iteration_number), 64'd1);

      // Random traffic: occasional resets with fresh seeds, start pulses and knockouts.
      for (int k = 0; k < 4000; k++) begin
         bit r;
         bit s;
         bit l;
         r = ($urandom_range(0, 499) == 0);
         s = ($urandom_range(0, 49) == 0);
         l = ($urandom_range(0, 99) == 0);
         if (r) bus.seed = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
         apply_stimulus(r, s, l, int'($urandom_range(0, RULES - 1)));
      end
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
